obstacle_scheduler: RTL and testbench

Sequences the Car_Dash obstacle field. On each scroll tick it requests a fresh 16-lane row from the random sequence generator and shifts the visible row buffer one row toward the car. It also checks the bottom row against the car's lane and speeds up the scroll period as the run progresses. It sits between the game top level (start and car position in), the random row generator (request/response), and the display driver (row buffer out).

---
 rtl/obstacle_scheduler.sv | 149 ++++++++++++++
 tb/tb_obstacle_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: sequences the Car_Dash obstacle field.
// On every scroll tick the visible row buffer moves one row toward the car
// and a fresh row is fetched from the random row generator. The bottom row
// is checked against the car lane, and the scroll period shrinks every
// LEVEL_ROWS scrolls down to TICK_MIN.
// Optional build macro GAP_ROW_EN: only every second scroll in RUN fetches
// a new row, so an all-zero gap row always separates generated rows.
module obstacle_scheduler #(
   parameter int unsigned ROWS       = 8,
   parameter int unsigned TICK_INIT  = 50000000,
   parameter int unsigned TICK_MIN   = 10000000,
   parameter int unsigned TICK_STEP  = 2000000,
   parameter int unsigned LEVEL_ROWS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         car_lane,
   output logic               seq_req,
   input  logic               seq_valid,
   input  logic [15:0]        seq,
   output logic [16*ROWS-1:0] rows,
   output logic               scroll,
   output logic               collision,
   output logic [15:0]        score,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RUN,
      S_CRASH
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] tick_cnt;
   logic [31:0] period;
   logic [31:0] level_cnt;
   logic [15:0] bottom;

   logic active;     // tick counter and collision check are live
   logic hit;        // car lane occupied in the bottom row
   logic go;         // start accepted (IDLE or CRASH)
   logic tick_wrap;  // tick counter at period-1
   logic do_scroll;  // shift actually performed (no collision this cycle)
   logic do_load;    // generator row actually captured

`ifdef GAP_ROW_EN
   logic gap_req;    // next RUN scroll fetches a row; cleared so the first RUN scroll leaves a gap
`endif

   assign bottom = rows[16*(ROWS-1) +: 16];

   // Next-state and per-cycle control decode; collision overrides scroll and load.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_nxt = state;
      active    = (state == S_REQ) || (state == S_WAIT) || (state == S_RUN);
      hit       = active && bottom[car_lane];
      go        = start && ((state == S_IDLE) || (state == S_CRASH));
      tick_wrap = active && (tick_cnt == period - 32'd1);
      do_scroll = tick_wrap && !hit;
      do_load   = (state == S_WAIT) && seq_valid && !hit;

      unique case (state)
         S_IDLE:  if (start) state_nxt = S_REQ;
         S_REQ:   state_nxt = S_WAIT;
         S_WAIT:  if (seq_valid) state_nxt = S_RUN;
         S_RUN: begin
`ifdef GAP_ROW_EN
            if (tick_wrap && gap_req) state_nxt = S_REQ;
`else
            if (tick_wrap) state_nxt = S_REQ;
`endif
         end
         S_CRASH: if (start) state_nxt = S_REQ;
         default: state_nxt = S_IDLE;
      endcase

      if (hit) state_nxt = S_CRASH;
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with <= so every register samples pre-edge values, independent of block order.
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Row buffer, tick/level counters, period, score and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the row buffer is driven straight to the display, so it is reset like any control register rather than left as uninitialised storage.
         rows      <= '0;
         tick_cnt  <= '0;
         level_cnt <= '0;
         period    <= TICK_INIT;
         score     <= '0;
         seq_req   <= 1'b0;
         scroll    <= 1'b0;
         collision <= 1'b0;
         busy      <= 1'b0;
      end else begin
         seq_req   <= (state_nxt == S_REQ);
         busy      <= (state_nxt == S_REQ) || (state_nxt == S_WAIT) || (state_nxt == S_RUN);
         collision <= (state_nxt == S_CRASH);
         scroll    <= do_scroll;

         if (go) begin
            rows      <= '0;
            tick_cnt  <= '0;
            level_cnt <= '0;
            period    <= TICK_INIT;
            score     <= '0;
         end else if (active && !hit) begin
            tick_cnt <= tick_wrap ? 32'd0 : tick_cnt + 32'd1;

            // Shift first; a coinciding generator row lands in the new top row.
            if (do_scroll)
               rows <= {rows[16*(ROWS-1)-1:0], (do_load ? seq : 16'h0000)};
            else if (do_load)
               rows[15:0] <= seq;

            if (do_scroll) begin
               if (score != 16'hFFFF) score <= score + 16'd1;
               if (level_cnt == LEVEL_ROWS - 1) begin
                  level_cnt <= '0;
                  // Compare before subtracting so the period can never wrap below zero.
                  period    <= (period >= TICK_MIN + TICK_STEP) ? period - TICK_STEP : TICK_MIN;
               end else begin
                  level_cnt <= level_cnt + 32'd1;
               end
            end
         end
      end
   end

`ifdef GAP_ROW_EN
   // Alternate fetch/gap on scrolls taken in RUN; restarted by every accepted start.
   always_ff @(posedge clk) begin
      if (rst || go)                        gap_req <= 1'b0;
      else if ((state == S_RUN) && do_scroll) gap_req <= ~gap_req;
   end
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: self-checking bench for obstacle_scheduler with a
// small generator model. Rows handed to the DUT are pushed to a scoreboard
// queue and popped when the DUT is expected to have captured them.
// Outputs are sampled on the falling edge; k counts rising edges after the
// edge that accepted start.
module tb_obstacle_scheduler;

   localparam int unsigned ROWS = 4;

   logic               clk;
   logic               rst;
   logic               start;
   logic [3:0]         car_lane;
   logic               seq_req;
   logic               seq_valid;
   logic [15:0]        seq;
   logic [16*ROWS-1:0] rows;
   logic               scroll;
   logic               collision;
   logic [15:0]        score;
   logic               busy;

   int n_checks = 0;
   int n_fails  = 0;

   // Generator model controls.
   int          gen_delay  = 2;
   bit          gen_en     = 1'b0;
   bit          gen_expect = 1'b1;
   logic [15:0] gen_row    = 16'h0000;
   logic [15:0] exp_q[$];

   obstacle_scheduler #(
      .ROWS(ROWS), .TICK_INIT(4), .TICK_MIN(2), .TICK_STEP(1), .LEVEL_ROWS(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .car_lane(car_lane),
      .seq_req(seq_req), .seq_valid(seq_valid), .seq(seq),
      .rows(rows), .scroll(scroll), .collision(collision),
      .score(score), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Generator: answers a seen seq_req gen_delay cycles later with a one-cycle row.
   initial begin : gen_model
      seq_valid = 1'b0;
      seq       = 16'h0000;
      forever begin
         @(negedge clk);
         if (seq_req && gen_en) begin
            repeat (gen_delay - 1) @(negedge clk);
            seq       = gen_row;
            seq_valid = 1'b1;
            exp_q.push_back(gen_expect ? gen_row : 16'h0000);
            @(negedge clk);
            seq_valid = 1'b0;
            check("row0_load", 64'(rows[15:0]), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse start for one cycle; returns at the falling edge after it was accepted (k = 0).
   task automatic start_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Stop answering requests and let any in-flight response complete.
   task automatic quiesce();
      gen_en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int exp_scroll[$];
      int nscroll;
      int nreq;

      rst      = 1'b1;
      start    = 1'b0;
      car_lane = 4'd0;
      repeat (2) @(negedge clk);

      // Reset values.
      check("rst_seq_req",   64'(seq_req),   64'd0);
      check("rst_rows",      64'(rows),      64'd0);
      check("rst_scroll",    64'(scroll),    64'd0);
      check("rst_collision", 64'(collision), 64'd0);
      check("rst_score",     64'(score),     64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      rst = 1'b0;
      @(negedge clk);

      // First row after start.
      gen_row = 16'h8001;
      gen_en  = 1'b1;
      start_run();
      check("start_seq_req", 64'(seq_req), 64'd1);
      check("start_busy",    64'(busy),    64'd1);
      @(negedge clk);
      check("seq_req_once",  64'(seq_req), 64'd0);
      @(negedge clk);
      check("run_busy",      64'(busy),      64'd1);
      check("run_collision", 64'(collision), 64'd0);
      quiesce();

      // Scroll cadence: period 4, 4, then 3, 3, then floor 2.
      do_reset();
      gen_row  = 16'h0010;
      car_lane = 4'd0;
      gen_en   = 1'b1;
      exp_scroll = '{4, 8, 11, 14, 16, 18};
      nscroll    = 0;
      start_run();
      for (int k = 1; k <= 18; k++) begin
         bit is_exp;
         @(negedge clk);
         is_exp = (exp_scroll.size() > 0) && (exp_scroll[0] == k);
         check($sformatf("scroll_k%0d", k), 64'(scroll), 64'(is_exp));
         if (is_exp) begin
            void'(exp_scroll.pop_front());
            nscroll++;
            check("score_inc",  64'(score),     64'(nscroll));
            check("no_collide", 64'(collision), 64'd0);
         end
      end
      quiesce();

      // Collision: lane-3 obstacle reaches the bottom row.
      do_reset();
      car_lane = 4'd3;
      gen_row  = 16'h0008;
      gen_en   = 1'b1;
      start_run();
      repeat (2) @(negedge clk);
      gen_row = 16'h0000;
      repeat (8) @(negedge clk);
      gen_en = 1'b0;
      @(negedge clk);
      check("crash_bottom",   64'(rows[63:48]), 64'h0008);
      check("crash_pre_coll", 64'(collision),   64'd0);
      check("crash_pre_scr",  64'(score),       64'd3);
      @(negedge clk);
      check("crash_coll",     64'(collision), 64'd1);
      check("crash_busy",     64'(busy),      64'd0);
      check("crash_score",    64'(score),     64'd3);
      repeat (5) @(negedge clk);
      check("frozen_score",   64'(score),       64'd3);
      check("frozen_bottom",  64'(rows[63:48]), 64'h0008);
      check("frozen_coll",    64'(collision),   64'd1);
      gen_row = 16'h0100;
      gen_en  = 1'b1;
      start_run();
      check("restart_rows",    64'(rows),      64'd0);
      check("restart_coll",    64'(collision), 64'd0);
      check("restart_seq_req", 64'(seq_req),   64'd1);
      check("restart_score",   64'(score),     64'd0);
      quiesce();

      // Slow generator: blank shift, one request, late row coincides with scroll.
      do_reset();
      car_lane  = 4'd0;
      gen_row   = 16'h0420;
      gen_delay = 8;
      gen_en    = 1'b1;
      nreq      = 0;
      start_run();
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) @(negedge clk);
         nreq += int'(seq_req);
         if (k == 4) begin
            check("slow_scroll1", 64'(scroll), 64'd1);
            check("slow_blank",   64'(rows),   64'd0);
         end
         if (k == 8) begin
            check("slow_scroll2", 64'(scroll),       64'd1);
            check("slow_upper",   64'(rows[63:16]),  64'd0);
         end
      end
      check("slow_one_req", 64'(nreq), 64'd1);
      gen_delay = 2;
      quiesce();

      // Reset during WAIT, then a late row arrives.
      do_reset();
      gen_row    = 16'hFFFF;
      gen_delay  = 3;
      gen_expect = 1'b0;
      gen_en     = 1'b1;
      start_run();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("late_rows",      64'(rows),      64'd0);
      check("late_seq_req",   64'(seq_req),   64'd0);
      check("late_busy",      64'(busy),      64'd0);
      check("late_score",     64'(score),     64'd0);
      check("late_collision", 64'(collision), 64'd0);
      check("late_scroll",    64'(scroll),    64'd0);
      gen_expect = 1'b1;
      gen_delay  = 2;
      quiesce();

`ifdef GAP_ROW_EN
      // Gap build: first RUN scroll leaves a gap, the next one fetches.
      do_reset();
      car_lane = 4'd0;
      gen_row  = 16'h0010;
      gen_en   = 1'b1;
      start_run();
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 4 || k == 8 || k == 11 || k == 14) begin
            check($sformatf("gap_scroll_k%0d", k), 64'(scroll),  64'd1);
            check($sformatf("gap_req_k%0d", k),    64'(seq_req), 64'(k == 8 || k == 14));
         end
         if (k == 10)
            check("gap_rows", 64'(rows), 64'h0000_0010_0000_0010);
      end
      quiesce();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
